gen_sequencer: RTL
==================

Name: gen_sequencer

Overview:
- Parametrised successor to the fixed 720-row line iterator; drives full generations of the cellular-automaton update.
- Issues row indices, with wrapped or edge-flagged neighbour indices, to the line buffer over a valid/ready handshake.
- Drains the next-state pipeline, then flips the read/write BRAM bank select.
- Supports run, single-step and mode-change restart, with generation starts gated to frame sync.

Parameters:
ROWS, 720, rows per generation (≥3)
ROW_W, 10, row index width, ceil(log2(ROWS))
GEN_W, 16, generation counter width
GENS_PER_FRAME, 1, generations computed per frame_sync pulse while running (≥1)
DRAIN_CYCLES, 4, cycles from last row accept until the final write-back is committed (≥1)
WRAP, 1, 1 = toroidal neighbour rows; 0 = dead-edge rows flagged

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
mode  in  1  display/calc mode level; any edge forces restart
run  in  1  level; continuous generations
step  in  1  pulse; one generation when not running
frame_sync  in  1  one-cycle pulse at frame boundary
calc_valid  out  1  row request valid
calc_ready  in  1  line buffer accepts row (valid_set)
calc_row  out  ROW_W  row being computed
row_above  out  ROW_W  neighbour index above
row_below  out  ROW_W  neighbour index below
edge_top  out  1  WRAP=0 and calc_row==0: above row is dead
edge_bot  out  1  WRAP=0 and calc_row==ROWS-1: below row is dead
buf_sel  out  1  read bank; write bank is ~buf_sel
busy  out  1  state not IDLE
gen_done  out  1  one-cycle pulse on bank swap
gen_count  out  GEN_W  completed generations, wraps modulo 2^GEN_W

Behaviour:
- Reset values: calc_valid=0, calc_row=0, buf_sel=0, busy=0, gen_done=0, gen_count=0, state=IDLE, per-frame counter=0, mode_q=mode.
- mode_q is registered every cycle. mode_chg = mode ^ mode_q.
- States: IDLE, WAIT_SYNC, ISSUE, DRAIN, SWAP.
- IDLE:
  - step=1 → ISSUE next cycle.
  - run=1 (and step=0) → WAIT_SYNC.
  - step and run both high → step wins.
- WAIT_SYNC:
  - frame_sync=1 → ISSUE and clear the per-frame counter.
  - run=0 → IDLE.
- ISSUE:
  - calc_valid=1. calc_row, row_above, row_below and edge flags are registered and stable while calc_valid=1 and calc_ready=0.
  - Accept is calc_valid & calc_ready. On accept with calc_row<ROWS-1, calc_row increments next cycle and calc_valid stays high, so back-to-back accepts give one row per cycle.
  - On accept with calc_row==ROWS-1: calc_valid=0, calc_row=0, → DRAIN with drain counter = DRAIN_CYCLES-1.
- DRAIN:
  - Counter decrements each cycle; at 0 → SWAP. calc_valid stays 0.
- SWAP (one cycle):
  - buf_sel toggles, gen_done=1, gen_count+1, per-frame counter+1.
  - Next state:
    - run=0 → IDLE.
    - run=1 and per-frame count < GENS_PER_FRAME → ISSUE immediately.
    - otherwise → WAIT_SYNC.
- Neighbour rows:
  - WRAP=1: row_above = (calc_row==0)?ROWS-1:calc_row-1; row_below = (calc_row==ROWS-1)?0:calc_row+1; edge flags 0.
  - WRAP=0: indices clamp to calc_row at the edges and the edge flags assert.
- Restart: mode_chg=1 in any state → next cycle state=IDLE, calc_valid=0, calc_row=0. buf_sel and gen_count are unchanged. Restart has priority over every other transition, including SWAP.
- step while busy is ignored. frame_sync outside WAIT_SYNC is ignored.
- Latency: step in IDLE → calc_valid=1 the next cycle. Minimum generation time is ROWS+DRAIN_CYCLES+1 cycles.
- Reset mid-generation → full reset values; no partial swap.

Decomposition:
- Shared package gol_pkg holds:
  - state enum (IDLE, WAIT_SYNC, ISSUE, DRAIN, SWAP)
  - default ROWS=720 and COLS=1280 constants
  - ROW_W derivation function (clog2)
- Sub-module row_neighbours: combinational index/wrap/edge logic, parametrised by ROWS, ROW_W, WRAP. Its outputs are registered in gen_sequencer.

Test Plan:
- ROWS=8, DRAIN_CYCLES=3, calc_ready tied 1, step pulse → calc_row 0..7 on 8 consecutive cycles; gen_done 12 cycles after the first calc_valid (8+3+1); buf_sel 0→1; gen_count=1.
- calc_ready toggled 1/0 pseudo-randomly → calc_row never changes while calc_valid&~calc_ready; each row 0..7 accepted exactly once, in order.
- WRAP=1, row 0 → row_above=7, row_below=1. WRAP=0, row 7 → row_below=7, edge_bot=1. edge_top=1 only at row 0.
- run=1, GENS_PER_FRAME=2, frame_sync every 100 cycles → two gen_done pulses per frame_sync, no ISSUE between the second SWAP and the next frame_sync.
- mode toggled during row 5 → calc_valid=0 next cycle, calc_row=0, state IDLE, buf_sel and gen_count unchanged. A later step restarts from row 0.
- reset asserted during DRAIN → all outputs at reset values next cycle; no gen_done pulse emitted.

Source files
------------

// File: rtl/gol_pkg.sv
// Shared types and constants for the cellular-automaton generation pipeline.
package gol_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SYNC,
    ISSUE,
    DRAIN,
    SWAP
  } seq_state_t;

  localparam int DEFAULT_ROWS = 720;
  localparam int DEFAULT_COLS = 1280;

  function automatic int row_w_for(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/gen_sequencer_if.sv
// Row request channel from the generation sequencer to the line buffer.
interface gen_sequencer_if #(
  parameter int ROW_W = 10
);
  logic             calc_valid;
  logic             calc_ready;
  logic [ROW_W-1:0] calc_row;
  logic [ROW_W-1:0] row_above;
  logic [ROW_W-1:0] row_below;
  logic             edge_top;
  logic             edge_bot;

  modport master (
    output calc_valid, calc_row, row_above, row_below, edge_top, edge_bot,
    input  calc_ready
  );

  modport slave (
    input  calc_valid, calc_row, row_above, row_below, edge_top, edge_bot,
    output calc_ready
  );
endinterface

// File: rtl/row_neighbours.sv
// Combinational neighbour-row indices: toroidal wrap, or clamped with dead-edge flags.
module row_neighbours import gol_pkg::*; #(
  parameter int ROWS  = DEFAULT_ROWS,
  parameter int ROW_W = row_w_for(ROWS),
  parameter bit WRAP  = 1'b1
) (
  input  logic [ROW_W-1:0] row,
  output logic [ROW_W-1:0] above,
  output logic [ROW_W-1:0] below,
  output logic             edge_top,
  output logic             edge_bot
);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

  logic at_top;
  logic at_bot;

  assign at_top = (row == '0);
  assign at_bot = (row == LAST_ROW);

  generate
    if (WRAP) begin : g_wrap
      assign above    = at_top ? LAST_ROW : row - ROW_ONE;
      assign below    = at_bot ? '0 : row + ROW_ONE;
      assign edge_top = 1'b0;
      assign edge_bot = 1'b0;
    end else begin : g_dead
      // Edge rows point at themselves; the flags tell the line buffer to substitute dead cells.
      assign above    = at_top ? row : row - ROW_ONE;
      assign below    = at_bot ? row : row + ROW_ONE;
      assign edge_top = at_top;
      assign edge_bot = at_bot;
    end
  endgenerate
endmodule

// File: rtl/gen_sequencer.sv
// Generation sequencer: issues every row to the line buffer, drains the pipeline, then swaps banks.
module gen_sequencer import gol_pkg::*; #(
  parameter int ROWS           = DEFAULT_ROWS,
  parameter int ROW_W          = row_w_for(ROWS),
  parameter int GEN_W          = 16,
  parameter int GENS_PER_FRAME = 1,
  parameter int DRAIN_CYCLES   = 4,
  parameter bit WRAP           = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic             run,
  input  logic             step,
  input  logic             frame_sync,
  gen_sequencer_if.master  calc,
  output logic             buf_sel,
  output logic             busy,
  output logic             gen_done,
  output logic [GEN_W-1:0] gen_count
);
  localparam int FC_W = $clog2(GENS_PER_FRAME + 1);
  localparam int DR_W = $clog2(DRAIN_CYCLES + 1);

  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(ROWS - 1);
  localparam logic [ROW_W-1:0] ROW_ONE    = ROW_W'(1);
  localparam logic [FC_W-1:0]  FRAME_MAX  = FC_W'(GENS_PER_FRAME);
  localparam logic [FC_W-1:0]  FRAME_ONE  = FC_W'(1);
  localparam logic [DR_W-1:0]  DRAIN_LOAD = DR_W'(DRAIN_CYCLES - 1);
  localparam logic [DR_W-1:0]  DRAIN_ONE  = DR_W'(1);
  localparam logic [GEN_W-1:0] GEN_ONE    = GEN_W'(1);

  seq_state_t       state_reg, state_next;
  logic             calc_valid_reg, calc_valid_next;
  logic [ROW_W-1:0] calc_row_reg, calc_row_next;
  logic [DR_W-1:0]  drain_reg, drain_next;
  logic [FC_W-1:0]  frame_reg, frame_next;
  logic             buf_sel_reg, buf_sel_next;
  logic             gen_done_reg, gen_done_next;
  logic [GEN_W-1:0] gen_count_reg, gen_count_next;
  logic             mode_q_reg;

  logic             mode_chg;
  logic             accept;
  logic [FC_W-1:0]  frame_inc;

  assign mode_chg  = mode ^ mode_q_reg;
  assign accept    = calc_valid_reg & calc.calc_ready;
  // Saturate so a run enabled mid-step cannot wrap the per-frame count.
  assign frame_inc = (frame_reg == FRAME_MAX) ? frame_reg : frame_reg + FRAME_ONE;

  always_comb begin
    state_next      = state_reg;
    calc_valid_next = calc_valid_reg;
    calc_row_next   = calc_row_reg;
    drain_next      = drain_reg;
    frame_next      = frame_reg;
    buf_sel_next    = buf_sel_reg;
    gen_done_next   = 1'b0;
    gen_count_next  = gen_count_reg;

    if (mode_chg) begin
      state_next      = IDLE;
      calc_valid_next = 1'b0;
      calc_row_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (step) begin
            state_next      = ISSUE;
            calc_valid_next = 1'b1;
            calc_row_next   = '0;
          end else if (run) begin
            state_next = WAIT_SYNC;
          end
        end
        WAIT_SYNC: begin
          if (frame_sync) begin
            state_next      = ISSUE;
            calc_valid_next = 1'b1;
            calc_row_next   = '0;
            frame_next      = '0;
          end else if (!run) begin
            state_next = IDLE;
          end
        end
        ISSUE: begin
          if (accept) begin
            if (calc_row_reg == LAST_ROW) begin
              state_next      = DRAIN;
              calc_valid_next = 1'b0;
              calc_row_next   = '0;
              drain_next      = DRAIN_LOAD;
            end else begin
              calc_row_next = calc_row_reg + ROW_ONE;
            end
          end
        end
        DRAIN: begin
          if (drain_reg == '0) state_next = SWAP;
          else                 drain_next = drain_reg - DRAIN_ONE;
        end
        SWAP: begin
          buf_sel_next   = ~buf_sel_reg;
          gen_done_next  = 1'b1;
          gen_count_next = gen_count_reg + GEN_ONE;
          frame_next     = frame_inc;
          if (!run) begin
            state_next = IDLE;
          end else if (frame_inc < FRAME_MAX) begin
            state_next      = ISSUE;
            calc_valid_next = 1'b1;
            calc_row_next   = '0;
          end else begin
            state_next = WAIT_SYNC;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      calc_valid_reg <= 1'b0;
      calc_row_reg   <= '0;
      drain_reg      <= '0;
      frame_reg      <= '0;
      buf_sel_reg    <= 1'b0;
      gen_done_reg   <= 1'b0;
      gen_count_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      calc_valid_reg <= calc_valid_next;
      calc_row_reg   <= calc_row_next;
      drain_reg      <= drain_next;
      frame_reg      <= frame_next;
      buf_sel_reg    <= buf_sel_next;
      gen_done_reg   <= gen_done_next;
      gen_count_reg  <= gen_count_next;
    end
    mode_q_reg <= mode;
  end

  // Neighbour indices are computed from the row about to be presented so they register alongside it.
  logic [ROW_W-1:0] nb_row;
  logic [ROW_W-1:0] above_next, below_next;
  logic             edge_top_next, edge_bot_next;
  logic [ROW_W-1:0] above_reg, below_reg;
  logic             edge_top_reg, edge_bot_reg;

  assign nb_row = reset ? '0 : calc_row_next;

  row_neighbours #(
    .ROWS  (ROWS),
    .ROW_W (ROW_W),
    .WRAP  (WRAP)
  ) u_neighbours (
    .row      (nb_row),
    .above    (above_next),
    .below    (below_next),
    .edge_top (edge_top_next),
    .edge_bot (edge_bot_next)
  );

  always_ff @(posedge clk) begin
    above_reg    <= above_next;
    below_reg    <= below_next;
    edge_top_reg <= edge_top_next;
    edge_bot_reg <= edge_bot_next;
  end

  assign calc.calc_valid = calc_valid_reg;
  assign calc.calc_row   = calc_row_reg;
  assign calc.row_above  = above_reg;
  assign calc.row_below  = below_reg;
  assign calc.edge_top   = edge_top_reg;
  assign calc.edge_bot   = edge_bot_reg;

  assign buf_sel   = buf_sel_reg;
  assign busy      = (state_reg != IDLE);
  assign gen_done  = gen_done_reg;
  assign gen_count = gen_count_reg;
endmodule
